dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Data-memory responder serving the load/store requests issued by the pipelined core's memory stage. It accepts one request at a time on a valid/ready handshake and inserts a configurable number of wait states. It returns sign- or zero-extended read data on a one-cycle response pulse. While a request is in flight it drives a busy signal that the hazard unit folds into its stall and flush logic.

Parameters:
DEPTH, 256, number of 32-bit words in the memory array; word index is req_addr[log2(DEPTH)+1:2].
WAIT_CYCLES, 2, wait states between accept and response; legal range 0..15.

Ports:
clk  input  1  clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-aligned.
req_ready  output  1  request can be accepted this cycle.
resp_valid  output  1  one-cycle response pulse.
resp_rdata  output  32  load result; held until the next response.
resp_err  output  1  request faulted; valid with resp_valid.
busy  output  1  stall request to the hazard unit.

Behaviour:
- Reset values: state IDLE, wait counter 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0. Memory contents are not cleared.
- Reset mid-operation: aborts the request. No write is committed if reset is high on the commit edge.
- Handshake: a request is accepted when state==IDLE and req_valid=1 (req_ready=1 only in IDLE). req_we, req_size, req_unsigned, req_addr and req_wdata are latched on the accept edge. Later changes to the req_* inputs are ignored until the next IDLE.
- State machine:
  - IDLE: on accept, go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - WAIT: counter loads WAIT_CYCLES-1 on accept and decrements each cycle; at 0, go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then return to IDLE. A new request can be accepted on the following cycle at the earliest.
- Latency: if accepted at edge N, resp_valid is high during cycle N+1+WAIT_CYCLES.
- busy = (IDLE && req_valid) || WAIT. busy is low in RESP so the pipeline advances in the same cycle it sees the data.
- Commit edge: the edge entering RESP. On that edge the store is written and resp_rdata/resp_err are registered.
- Store:
  - byte writes req_wdata[7:0] to lane addr[1:0];
  - half writes req_wdata[15:0] to lanes {addr[1],0} and {addr[1],1};
  - word writes all 4 lanes;
  - other lanes are untouched; resp_rdata=0 for stores.
- Load: selects the lane(s) by addr[1:0] and extends to 32 bits per req_unsigned. A word load ignores req_unsigned.
- Faults (resp_err=1, no write, resp_rdata=0) when any of these hold:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - req_size=11;
  - word index >= DEPTH, i.e. any address bit above the index range is set.
- Back-to-back: req_valid held high across RESP is accepted again in the next IDLE cycle. There is no combinational path from req_valid to req_ready.

Optional Feature:
DMEM_MMIO_EN:
- Defined: adds output ports mmio_out (32 bits, reset 0) and mmio_strobe (1 bit, reset 0).
  - A word store to 0xFFFF_FFF0 updates mmio_out on the commit edge and pulses mmio_strobe during the RESP cycle. It does not write the array and resp_err=0.
  - A word load from 0xFFFF_FFF0 returns mmio_out.
  - A non-word access to 0xFFFF_FFF0 faults.
- Not defined: the ports are absent and 0xFFFF_FFF0 is out of range, so any access to it faults.

Test Plan:
- Reset, then word store 0xDEADBEEF to 0x10 accepted at edge N with WAIT_CYCLES=2 -> busy high cycles N..N+2, resp_valid only in cycle N+3, resp_err=0; a later word load from 0x10 returns 0xDEADBEEF.
- Word 0x8081_7F80 at 0x20; byte loads from 0x20, 0x21, 0x22 and 0x23, signed -> 0xFFFFFF80, 0x0000007F, 0xFFFFFF81, 0xFFFFFF80; byte load from 0x20 unsigned -> 0x00000080; signed half load from 0x22 -> 0xFFFF8081.
- Byte store 0xAA to 0x21 over 0x11223344 -> word reads 0x1122AA44; half store 0x5566 to 0x22 -> word reads 0x5566AA44.
- Misaligned word load from 0x06, half store to 0x03, and req_size=11 -> resp_err=1, resp_rdata=0, memory unchanged.
- WAIT_CYCLES=0 with req_valid held high for 3 requests -> resp_valid every other cycle; reset asserted on the commit edge of a store -> no write, all outputs at reset values.
- With DMEM_MMIO_EN: word store 0x00000001 to 0xFFFF_FFF0 -> mmio_out=1 and mmio_strobe pulses once; load from the same address returns 1.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, one-cycle response pulse.
// Optional memory-mapped output register at 0xFFFF_FFF0 when DMEM_MMIO_EN is defined.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] mmio_out,
  output logic        mmio_strobe
`endif
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_t;

  state_t      state, state_n;
  logic [3:0]  wait_cnt;
  logic        accept, commit;

  logic        lat_we, lat_unsigned;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr, lat_wdata;

  logic        e_we, e_unsigned;
  logic [1:0]  e_size;
  logic [31:0] e_addr, e_wdata;

  logic [AW-1:0] idx;
  logic          oor, fault, mmio_hit, wr_en;
  logic [31:0]   word_rd, ld_data, rdata_n, wr_data;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [3:0]    wr_be;

  logic [31:0] mem [DEPTH];

  assign accept     = (state == S_IDLE) && req_valid;
  assign commit     = (state_n == S_RESP) && (state != S_RESP);
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = req_valid;
        if (req_valid) state_n = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_cnt == 4'd0) state_n = S_RESP;
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so the live inputs are used then.
  always_comb begin
    e_we       = accept ? req_we       : lat_we;
    e_size     = accept ? req_size     : lat_size;
    e_unsigned = accept ? req_unsigned : lat_unsigned;
    e_addr     = accept ? req_addr     : lat_addr;
    e_wdata    = accept ? req_wdata    : lat_wdata;

    idx      = e_addr[AW+1:2];
    oor      = e_addr[31:2] >= 30'(DEPTH);
    mmio_hit = 1'b0;
`ifdef DMEM_MMIO_EN
    mmio_hit = (e_addr == 32'hFFFF_FFF0) && (e_size == SZ_WORD);
`endif

    fault = 1'b0;
    unique case (e_size)
      SZ_HALF: fault = e_addr[0];
      SZ_WORD: fault = (e_addr[1:0] != 2'b00);
      SZ_RSVD: fault = 1'b1;
      default: fault = 1'b0;
    endcase
    fault = fault || (oor && !mmio_hit);

    word_rd = oor ? 32'd0 : mem[idx];
    unique case (e_addr[1:0])
      2'd0:    byte_v = word_rd[7:0];
      2'd1:    byte_v = word_rd[15:8];
      2'd2:    byte_v = word_rd[23:16];
      default: byte_v = word_rd[31:24];
    endcase
    half_v = e_addr[1] ? word_rd[31:16] : word_rd[15:0];

    ld_data = 32'd0;
    wr_be   = 4'b0000;
    wr_data = e_wdata;
    unique case (e_size)
      SZ_BYTE: begin
        ld_data = {{24{~e_unsigned & byte_v[7]}}, byte_v};
        wr_be   = 4'b0001 << e_addr[1:0];
        wr_data = {4{e_wdata[7:0]}};
      end
      SZ_HALF: begin
        ld_data = {{16{~e_unsigned & half_v[15]}}, half_v};
        wr_be   = e_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{e_wdata[15:0]}};
      end
      SZ_WORD: begin
        ld_data = word_rd;
`ifdef DMEM_MMIO_EN
        if (mmio_hit) ld_data = mmio_out;
`endif
        wr_be   = 4'b1111;
      end
      default: ;
    endcase

    rdata_n = (fault || e_we) ? 32'd0 : ld_data;
    wr_en   = commit && e_we && !fault && !mmio_hit;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      wait_cnt     <= 4'd0;
      resp_rdata   <= 32'd0;
      resp_err     <= 1'b0;
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
`ifdef DMEM_MMIO_EN
      mmio_out     <= 32'd0;
      mmio_strobe  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        wait_cnt     <= WAIT_INIT;
        lat_we       <= req_we;
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
        lat_addr     <= req_addr;
        lat_wdata    <= req_wdata;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (commit) begin
        resp_rdata <= rdata_n;
        resp_err   <= fault;
      end
`ifdef DMEM_MMIO_EN
      mmio_strobe <= commit && e_we && mmio_hit;
      if (commit && e_we && mmio_hit) mmio_out <= e_wdata;
`endif
    end
  end

  // NOTE: the array is never reset; its contents survive reset and a held reset blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule
